fetch_pc_gen: RTL and testbench
===============================

Name: fetch_pc_gen

Overview:
Transmit end of the fetch PC stream. It produces sequential instruction addresses and presents them to the downstream PC stage under a valid/stall handshake. It redirects on flush and throttles issue against a credit counter of outstanding fetch requests, which fetch-response acknowledges decrement. It sits at the head of the front-end and is the sole source of pc_valid/pc_addr into the PC bypass stage.

Parameters:
XLEN, 32, address width.
RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
INST_BYTES, 4, sequential increment; power of two.
MAX_OUTSTANDING, 4, maximum issued-but-unacknowledged fetches; at least 1.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  synchronous, active-high.
stall_in  in  1  downstream stall; while high, the presented PC is not consumed.
flush_in  in  1  pipeline flush/redirect request.
redirect_pc  in  XLEN  target address, sampled when flush_in=1.
resp_ack  in  1  one fetch response returned; frees one credit.
pc_valid  out  1  pc_addr is a fetch request this cycle.
pc_addr  out  XLEN  current fetch address.
outstanding  out  $clog2(MAX_OUTSTANDING+1)  live credit count.
err_underflow  out  1  sticky flag: resp_ack arrived with outstanding==0.

Behaviour:
- Clocking and reset: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: state=BOOT, pc_addr=RESET_VECTOR, outstanding=0, err_underflow=0, pc_valid=0.
- Reset has priority over every other input in the same cycle.
- Outputs are driven only from registered state. There is no combinational path from stall_in, flush_in or resp_ack to any output.
- States:
  - BOOT: one bubble cycle after reset, then RUN.
  - RUN: normal issue.
  - REDIRECT: one bubble cycle after a flush, then RUN.
- pc_valid = (state==RUN) && (outstanding < MAX_OUTSTANDING).
- issue = pc_valid && !stall_in && !flush_in.
- On issue:
  - pc_addr <= pc_addr + INST_BYTES, modulo 2^XLEN; wrap from all-ones region to 0 is silent.
  - outstanding increments.
- Stall (stall_in=1, no flush): pc_addr and state hold, so the same address is re-presented until consumed. The stall duration has no limit.
- Throttle (outstanding==MAX_OUTSTANDING): pc_valid=0 and pc_addr holds.
  - A resp_ack in the same cycle does not unblock that cycle.
  - pc_valid rises the following cycle.
- Flush (flush_in=1, reset=0), from any state:
  - pc_addr <= redirect_pc with low log2(INST_BYTES) bits forced to 0; state <= REDIRECT.
  - The current-cycle PC is not issued, even if stall_in=0.
  - Flush overrides stall and throttle.
  - Flush while in REDIRECT or BOOT re-targets and stays in (or enters) REDIRECT.
- Flush does not clear outstanding. Responses for squashed fetches still return and must be counted off.
- Credit counter update per cycle: +1 if issue, −1 if resp_ack && outstanding>0.
  - Issue and ack together: count unchanged.
  - Never exceeds MAX_OUTSTANDING and never goes below 0.
- resp_ack with outstanding==0: count stays 0 and err_underflow is set. It clears only on reset.
- Latency: the first valid PC appears 2 cycles after reset deassertion (BOOT bubble). Redirect target becomes valid 2 cycles after the flush cycle.

Test Plan:
- Reset release, stall_in=0, resp_ack held 1 → pc_valid=0 in cycle 1; from cycle 2, pc_addr=0x0,0x4,0x8,0xC on consecutive cycles, with outstanding steady at 1.
- No acks, MAX_OUTSTANDING=4 → exactly 4 issues (0x0..0xC), then pc_valid=0 with pc_addr=0x10 held. One resp_ack → pc_valid=1 the next cycle and 0x10 issues.
- stall_in high 5 cycles while pc_addr=0x8 → pc_addr stays 0x8, outstanding unchanged. 0x8 issues in the first cycle after stall drops, then 0xC.
- flush_in with redirect_pc=0x1003 during a stall with 3 outstanding → next cycle pc_valid=0 and pc_addr=0x1000, then pc_valid=1 at 0x1000. outstanding remains 3 until acks arrive.
- With pc_addr=0xFFFF_FFFC, issue → pc_addr=0x0000_0000, no error.
- resp_ack with outstanding=0 → err_underflow=1 and stays 1 through later traffic; outstanding stays 0. Reset asserted together with flush_in → pc_addr=RESET_VECTOR, err_underflow=0.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: sequential fetch PC generator with flush redirect and credit-based issue throttling
module fetch_pc_gen #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int INST_BYTES = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall_in,
  input  logic            flush_in,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            resp_ack,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_addr,
  output logic [CW-1:0]   outstanding,
  output logic            err_underflow
);
  typedef enum logic [1:0] {BOOT, RUN, REDIRECT} state_t;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);
  localparam logic [XLEN-1:0] INC = XLEN'(INST_BYTES);
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, err_q, issue, dec;
  always_comb begin
    issue = valid_q && !stall_in && !flush_in;
    dec = resp_ack && cnt_q != '0;
    state_d = flush_in ? REDIRECT : (state_q == BOOT || state_q == REDIRECT) ? RUN : state_q;
    pc_d = flush_in ? redirect_pc & ~(INC - XLEN'(1)) : issue ? pc_q + INC : pc_q;
    cnt_d = (issue && !dec) ? cnt_q + CW'(1) : (!issue && dec) ? cnt_q - CW'(1) : cnt_q;
  end
  // pc_valid is precomputed from next state so it leaves a flop
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      valid_q <= state_d == RUN && cnt_d < MAX_C;
      err_q   <= err_q | (resp_ack && cnt_q == '0);
    end
  end
  assign pc_valid = valid_q;
  assign pc_addr = pc_q;
  assign outstanding = cnt_q;
  assign err_underflow = err_q;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed vectors feed an expectation queue; a monitor checks outputs after every edge
module tb_fetch_pc_gen;
  logic clk = 1'b0;
  logic reset = 1'b1, stall_in = 1'b0, flush_in = 1'b0, resp_ack = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic pc_valid, err_underflow;
  logic [31:0] pc_addr;
  logic [2:0] outstanding;
  typedef struct packed {logic v; logic [31:0] a; logic [2:0] c; logic e;} exp_t;
  exp_t q[$];
  string q_nm[$];
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  fetch_pc_gen dut (
    .clock(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .redirect_pc(redirect_pc), .resp_ack(resp_ack), .pc_valid(pc_valid),
    .pc_addr(pc_addr), .outstanding(outstanding), .err_underflow(err_underflow)
  );

  task automatic t(input logic r, s, f, input logic [31:0] rp, input logic a,
                   input logic ev, input logic [31:0] ea, input logic [2:0] ec, input logic ee,
                   input string nm);
    @(negedge clk);
    reset = r; stall_in = s; flush_in = f; redirect_pc = rp; resp_ack = a;
    q.push_back('{ev, ea, ec, ee});
    q_nm.push_back(nm);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      string nm;
      e = q.pop_front();
      nm = q_nm.pop_front();
      n_checks++;
      if ({pc_valid, pc_addr, outstanding, err_underflow} !== e) begin
        n_fail++;
        $display("FAIL %s: got valid=%0b addr=%h out=%0d err=%0b, want valid=%0b addr=%h out=%0d err=%0b",
                 nm, pc_valid, pc_addr, outstanding, err_underflow, e.v, e.a, e.c, e.e);
      end
    end
  end

  initial begin
    // reset release with acks held high; the BOOT-cycle ack underflows
    t(1,0,0,0,0, 0,32'h0,0,0, "rst_a");
    t(1,0,0,0,0, 0,32'h0,0,0, "rst_b");
    t(0,0,0,0,1, 1,32'h0,0,1, "boot_bubble");
    t(0,0,0,0,1, 1,32'h4,1,1, "seq_0");
    t(0,0,0,0,1, 1,32'h8,1,1, "seq_4");
    t(0,0,0,0,1, 1,32'hC,1,1, "seq_8");
    t(0,0,0,0,1, 1,32'h10,1,1, "seq_c");
    // throttle with no acks
    t(1,0,0,0,0, 0,32'h0,0,0, "rst2");
    t(0,0,0,0,0, 1,32'h0,0,0, "boot2");
    t(0,0,0,0,0, 1,32'h4,1,0, "thr_0");
    t(0,0,0,0,0, 1,32'h8,2,0, "thr_4");
    t(0,0,0,0,0, 1,32'hC,3,0, "thr_8");
    t(0,0,0,0,0, 0,32'h10,4,0, "thr_full");
    t(0,0,0,0,0, 0,32'h10,4,0, "thr_hold");
    t(0,0,0,0,1, 1,32'h10,3,0, "thr_ack");
    t(0,0,0,0,0, 0,32'h14,4,0, "thr_issue10");
    // five-cycle stall at 0x8
    t(1,0,0,0,0, 0,32'h0,0,0, "rst3");
    t(0,0,0,0,0, 1,32'h0,0,0, "boot3");
    t(0,0,0,0,0, 1,32'h4,1,0, "st_0");
    t(0,0,0,0,0, 1,32'h8,2,0, "st_4");
    for (int i = 0; i < 5; i++) t(0,1,0,0,0, 1,32'h8,2,0, "stall_hold");
    t(0,0,0,0,0, 1,32'hC,3,0, "st_8");
    t(0,0,0,0,0, 0,32'h10,4,0, "st_c");
    // flush during stall with 3 outstanding
    t(0,0,0,0,1, 1,32'h10,3,0, "fl_ack");
    t(0,1,1,32'h1003,0, 0,32'h1000,3,0, "fl_redirect");
    t(0,0,0,0,0, 1,32'h1000,3,0, "fl_valid");
    t(0,0,0,0,0, 0,32'h1004,4,0, "fl_issue");
    t(0,0,0,0,1, 1,32'h1004,3,0, "fl_ack2");
    t(0,0,0,0,1, 1,32'h1008,3,0, "fl_issue_ack");
    // address wrap
    t(0,0,1,32'hFFFF_FFFC,0, 0,32'hFFFF_FFFC,3,0, "wr_flush");
    t(0,0,0,0,1, 1,32'hFFFF_FFFC,2,0, "wr_valid");
    t(0,0,0,0,0, 1,32'h0,3,0, "wr_wrap");
    t(0,0,0,0,0, 0,32'h4,4,0, "wr_next");
    // drain credits, then underflow
    t(0,1,0,0,1, 1,32'h4,3,0, "dr_3");
    t(0,1,0,0,1, 1,32'h4,2,0, "dr_2");
    t(0,1,0,0,1, 1,32'h4,1,0, "dr_1");
    t(0,1,0,0,1, 1,32'h4,0,0, "dr_0");
    t(0,1,0,0,1, 1,32'h4,0,1, "underflow");
    t(0,0,0,0,0, 1,32'h8,1,1, "uf_sticky");
    t(0,0,1,32'h2002,1, 0,32'h2000,0,1, "uf_flush_ack");
    t(0,0,1,32'h3005,0, 0,32'h3004,0,1, "reflush_redirect");
    t(0,0,0,0,0, 1,32'h3004,0,1, "reflush_valid");
    // reset wins over flush, then flush out of BOOT
    t(1,0,1,32'h5000,0, 0,32'h0,0,0, "rst_over_flush");
    t(0,0,1,32'h40,0, 0,32'h40,0,0, "boot_flush");
    t(0,0,0,0,0, 1,32'h40,0,0, "boot_flush_valid");
    @(negedge clk);
    flush_in = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
